wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
// Write-back side of the register-file write port. Accepts results from the ALU and load producers
// through valid/ready handshakes and buffers them in an in-order FIFO. Retires one entry per cycle
// onto the regfile write port (wr_num/wr_data/wr_en).
// Provides two forwarding lookups so the decode stage sees values that are queued but not yet
// visible in the regfile. Sits between the EX/MEM result buses and the regfile.
// PARAMETERS
// DEPTH   4   FIFO entries; power of two, >=2
// DATA_W  32  result/register data width
// NUM_W   5   register number width (32 architectural registers, r0 hardwired 0)
// PORTS
// clk        in   1       clock; all state updates on posedge
// rst_n      in   1       synchronous reset, active low
// ld_valid   in   1       load result valid
// ld_ready   out  1       load result accepted when ld_valid&&ld_ready
// ld_num     in   NUM_W   load destination register
// ld_data    in   DATA_W  load result
// alu_valid  in   1       ALU result valid
// alu_ready  out  1       ALU result accepted when alu_valid&&alu_ready
// alu_num    in   NUM_W   ALU destination register
// alu_data   in   DATA_W  ALU result
// wr_en      out  1       regfile write enable
// wr_num     out  NUM_W   regfile write register
// wr_data    out  DATA_W  regfile write data
// fwd0_num   in   NUM_W   lookup register, read port 0
// fwd0_hit   out  1       fwd0_num is pending in queue
// fwd0_data  out  DATA_W  newest pending value for fwd0_num (0 when no hit)
// fwd1_num   in   NUM_W   lookup register, read port 1
// fwd1_hit   out  1       same as fwd0, port 1
// fwd1_data  out  DATA_W  same as fwd0, port 1
// count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
// - Reset (rst_n low at posedge): count=0, rd/wr pointers=0, entries invalid.
//   While rst_n is low: wr_en=0, ld_ready=0, alu_ready=0, fwd*_hit=0, fwd*_data=0.
// - free = DEPTH-count, taken from registered count. A same-cycle pop does NOT free a slot for
//   same-cycle enqueue; readies have no path from the pop.
// - Writes to r0 (num==0) are accepted by the handshake, never stored, and consume no slot.
// - need_ld = ld_valid && ld_num!=0. ld_ready = free>=1 (1 even when free=0 if ld_num==0).
// - alu_ready = (alu_num==0) | (free >= 1+need_ld). Load has priority; an ALU result never
//   overtakes a load.
// - Both accepted in one cycle: load is stored first (older), then ALU; pointer advances by 2.
// - Drain: wr_en = (count!=0) && rst_n. wr_num/wr_data = head entry, combinational from storage.
//   Head pops at every posedge where wr_en=1. Latency from accept to wr_en is >=1 cycle:
//   an entry accepted into an empty queue appears on wr_en the next cycle.
// - count_next = count + accepted_stored - (wr_en?1:0). The result is never >DEPTH and never <0.
// - Forwarding: combinational compare of fwdN_num against all stored entries, including the head
//   currently on wr_en (the regfile updates only at the edge). The newest matching entry wins.
//   fwdN_num==0 never hits. Same-cycle incoming ld/alu data is not forwarded.
// - Pointers wrap modulo DEPTH. Ordering is strictly FIFO across the wrap.
// - Reset asserted mid-operation discards all queued entries; no further wr_en pulses occur.
// TESTING
// - Reset: hold rst_n=0 for 2 cycles with ld_valid=1 -> ld_ready=0, wr_en=0, count=0.
// - Single: alu r3=0x11 into empty queue -> next cycle wr_en=1, wr_num=3, wr_data=0x11;
//   the following cycle count=0 and wr_en=0.
// - Simultaneous: ld r5=0xAA and alu r6=0xBB, free=4 -> both accepted, count=2.
//   wr sequence is r5/0xAA then r6/0xBB.
// - Full: fill 4 entries -> ld_ready=0. Then ld r7 with free=1 and alu r8 valid -> load accepted,
//   alu_ready=0; r8 is accepted the cycle after a pop.
// - Forward: queue r4=0x1, r4=0x2 pending, fwd0_num=4 -> fwd0_hit=1, fwd0_data=0x2.
//   fwd1_num=0 -> fwd1_hit=0.
// - r0 drop: alu r0=0xFF with queue full -> alu_ready=1, count unchanged, r0 never on wr_num.
//   Wrap: 10 back-to-back writes retire in order.

Source files
------------

// File: rtl/wb_write_queue_if.sv
// Write-back queue bus bundle: load/ALU producer handshakes, regfile write port,
// two decode-stage forwarding lookups and the occupancy count.
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              ld_valid;
    logic              ld_ready;
    logic [NUM_W-1:0]  ld_num;
    logic [DATA_W-1:0] ld_data;

    logic              alu_valid;
    logic              alu_ready;
    logic [NUM_W-1:0]  alu_num;
    logic [DATA_W-1:0] alu_data;

    logic              wr_en;
    logic [NUM_W-1:0]  wr_num;
    logic [DATA_W-1:0] wr_data;

    logic [NUM_W-1:0]  fwd0_num;
    logic              fwd0_hit;
    logic [DATA_W-1:0] fwd0_data;
    logic [NUM_W-1:0]  fwd1_num;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;

    logic [CNT_W-1:0]  count;

    // The queue itself.
    modport slave (
        input  ld_valid, ld_num, ld_data,
        input  alu_valid, alu_num, alu_data,
        input  fwd0_num, fwd1_num,
        output ld_ready, alu_ready,
        output wr_en, wr_num, wr_data,
        output fwd0_hit, fwd0_data, fwd1_hit, fwd1_data,
        output count
    );

    // Producers, regfile and decode stage as seen from outside the queue.
    modport master (
        output ld_valid, ld_num, ld_data,
        output alu_valid, alu_num, alu_data,
        output fwd0_num, fwd1_num,
        input  ld_ready, alu_ready,
        input  wr_en, wr_num, wr_data,
        input  fwd0_hit, fwd0_data, fwd1_hit, fwd1_data,
        input  count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back FIFO between the EX/MEM result buses and the regfile write port.
// Loads take priority over ALU results; writes to r0 are swallowed without using a slot.
// Queued values are forwarded to decode until the regfile edge that retires them.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_W-1:0]  num_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;

    logic [CNT_W-1:0]  free;
    logic              need_ld;
    logic              need_alu;
    logic              ld_acc;
    logic              alu_acc;
    logic              pop;

    // Free slots come from the registered count only, so readies never depend on the pop.
    assign free     = CNT_W'(DEPTH) - count_q;
    assign need_ld  = bus.ld_valid  && (bus.ld_num  != '0);
    assign need_alu = bus.alu_valid && (bus.alu_num != '0);

    assign bus.ld_ready  = rst_n && ((bus.ld_num == '0) || (free >= CNT_W'(1)));
    assign bus.alu_ready = rst_n && ((bus.alu_num == '0) ||
                                     (free >= CNT_W'(1) + CNT_W'(need_ld)));

    assign ld_acc  = need_ld  && bus.ld_ready;
    assign alu_acc = need_alu && bus.alu_ready;

    assign pop         = rst_n && (count_q != '0);
    assign bus.wr_en   = pop;
    assign bus.wr_num  = num_q[rd_ptr];
    assign bus.wr_data = data_q[rd_ptr];
    assign bus.count   = count_q;

    // Pointer and occupancy bookkeeping; a load and an ALU result may both land in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(ld_acc) + PTR_W'(alu_acc);
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            count_q <= count_q + CNT_W'(ld_acc) + CNT_W'(alu_acc) - CNT_W'(pop);
        end
    end

    // Entry storage: the load goes in first (older), the ALU result right behind it.
    // NOTE: storage is not reset; an entry is only meaningful while inside the rd_ptr/count window.
    always_ff @(posedge clk) begin
        if (ld_acc) begin
            num_q[wr_ptr]  <= bus.ld_num;
            data_q[wr_ptr] <= bus.ld_data;
        end
        if (alu_acc) begin
            num_q[wr_ptr + PTR_W'(ld_acc)]  <= bus.alu_num;
            data_q[wr_ptr + PTR_W'(ld_acc)] <= bus.alu_data;
        end
    end

    // Forwarding lookup: scan oldest to newest so the newest matching entry wins.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        bus.fwd0_hit  = 1'b0;
        bus.fwd0_data = '0;
        bus.fwd1_hit  = 1'b0;
        bus.fwd1_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                if ((bus.fwd0_num != '0) && (num_q[rd_ptr + PTR_W'(k)] == bus.fwd0_num)) begin
                    bus.fwd0_hit  = 1'b1;
                    bus.fwd0_data = data_q[rd_ptr + PTR_W'(k)];
                end
                if ((bus.fwd1_num != '0) && (num_q[rd_ptr + PTR_W'(k)] == bus.fwd1_num)) begin
                    bus.fwd1_hit  = 1'b1;
                    bus.fwd1_data = data_q[rd_ptr + PTR_W'(k)];
                end
            end
        end
        if (!rst_n) begin
            bus.fwd0_hit  = 1'b0;
            bus.fwd0_data = '0;
            bus.fwd1_hit  = 1'b0;
            bus.fwd1_data = '0;
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted results are pushed into an expected FIFO,
// and each regfile write is popped and compared; readies, count and forwarding are
// predicted from the same expected FIFO every cycle.
module tb_wb_write_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int NUM_W  = 5;

    typedef struct {
        logic [NUM_W-1:0]  num;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    entry_t sb[$];

    wb_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_W(NUM_W)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_W(NUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Newest pending value for register n; r0 never hits.
    function automatic void fwd_model(input logic [NUM_W-1:0] n, output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (n != '0) begin
            foreach (sb[i]) begin
                if (sb[i].num == n) begin
                    hit = 1'b1;
                    d   = sb[i].data;
                end
            end
        end
    endfunction

    // One clock: inputs are already driven after the falling edge; check, update model, advance.
    task automatic step();
        int                free;
        logic              need_ld, exp_ldr, exp_alur, hit;
        logic [DATA_W-1:0] d;
        #1;
        if (!rst_n) begin
            check("rst_ld_ready",  bus.ld_ready,  0);
            check("rst_alu_ready", bus.alu_ready, 0);
            check("rst_wr_en",     bus.wr_en,     0);
            check("rst_fwd0_hit",  bus.fwd0_hit,  0);
            check("rst_fwd0_data", bus.fwd0_data, 0);
            check("rst_fwd1_hit",  bus.fwd1_hit,  0);
            check("rst_fwd1_data", bus.fwd1_data, 0);
        end else begin
            free     = DEPTH - sb.size();
            need_ld  = bus.ld_valid && (bus.ld_num != 0);
            exp_ldr  = (bus.ld_num == 0) || (free >= 1);
            exp_alur = (bus.alu_num == 0) || (free >= 1 + int'(need_ld));
            check("count",     bus.count,     sb.size());
            check("ld_ready",  bus.ld_ready,  exp_ldr);
            check("alu_ready", bus.alu_ready, exp_alur);
            check("wr_en",     bus.wr_en,     sb.size() != 0);
            if (sb.size() != 0) begin
                check("wr_num",  bus.wr_num,  sb[0].num);
                check("wr_data", bus.wr_data, sb[0].data);
            end
            fwd_model(bus.fwd0_num, hit, d);
            check("fwd0_hit",  bus.fwd0_hit,  hit);
            check("fwd0_data", bus.fwd0_data, d);
            fwd_model(bus.fwd1_num, hit, d);
            check("fwd1_hit",  bus.fwd1_hit,  hit);
            check("fwd1_data", bus.fwd1_data, d);
            if (sb.size() != 0) void'(sb.pop_front());
            if (need_ld && exp_ldr) sb.push_back('{bus.ld_num, bus.ld_data});
            if (bus.alu_valid && bus.alu_num != 0 && exp_alur)
                sb.push_back('{bus.alu_num, bus.alu_data});
        end
        @(posedge clk);
        if (!rst_n) sb.delete();
        @(negedge clk);
    endtask

    task automatic drive(input logic lv = 0, input logic [NUM_W-1:0] ln = 0,
                         input logic [DATA_W-1:0] ldd = 0, input logic av = 0,
                         input logic [NUM_W-1:0] an = 0, input logic [DATA_W-1:0] ad = 0,
                         input logic [NUM_W-1:0] f0 = 0, input logic [NUM_W-1:0] f1 = 0);
        bus.ld_valid  = lv;
        bus.ld_num    = ln;
        bus.ld_data   = ldd;
        bus.alu_valid = av;
        bus.alu_num   = an;
        bus.alu_data  = ad;
        bus.fwd0_num  = f0;
        bus.fwd1_num  = f1;
        step();
    endtask

    // Bounded drain: an expired budget shows up as a count miscompare.
    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) drive();
        check("drain_count", bus.count, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.ld_valid  = 1'b1;
        bus.ld_num    = 5'd5;
        bus.ld_data   = 32'h55;
        bus.alu_valid = 1'b0;
        bus.alu_num   = '0;
        bus.alu_data  = '0;
        bus.fwd0_num  = 5'd5;
        bus.fwd1_num  = '0;
        @(negedge clk);

        // Reset held two cycles with a load offered.
        step();
        step();
        check("rst_count", bus.count, 0);
        rst_n = 1'b1;

        // Single ALU write into an empty queue, retires the next cycle.
        drive(0, 0, 0, 1, 3, 32'h11);
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        drive();

        // Simultaneous load and ALU: load retires first.
        drive(1, 5, 32'hAA, 1, 6, 32'hBB);
        drive(0, 0, 0, 0, 0, 0, 5, 6);
        drive();
        drive();

        // Pressure: the constant drain caps occupancy at 3, leaving free=1.
        drive(1, 1, 32'h101, 1, 2, 32'h102);
        drive(1, 3, 32'h103, 1, 4, 32'h104);
        drive(1, 7, 32'h107, 1, 8, 32'h108);  // load taken, ALU stalled
        drive(0, 0, 0,       1, 8, 32'h108);  // ALU taken after the pop
        drive(1, 9, 32'h109, 1, 0, 32'hFF);   // r0 ALU accepted regardless of room
        drive(1, 0, 32'h0,   1, 10, 32'h10A); // r0 load frees the way for the ALU
        drain();

        // Forwarding: two pending writes to r4, newest wins; r0 never hits.
        drive(1, 4, 32'h1, 1, 4, 32'h2, 4, 0);
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        drive(0, 0, 0, 0, 0, 0, 4, 4);
        drive(0, 0, 0, 0, 0, 0, 4, 0);

        // Ten back-to-back writes wrap the pointers more than once.
        for (int i = 0; i < 10; i++)
            drive(0, 0, 0, 1, NUM_W'(i + 11), 32'h200 + 32'(i), NUM_W'(i + 10), NUM_W'(i + 11));
        drain();

        // Random traffic on a small register set to exercise hits and r0 drops.
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), NUM_W'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), NUM_W'($urandom_range(0, 7)), $urandom,
                  NUM_W'($urandom_range(0, 7)), NUM_W'($urandom_range(0, 7)));
        drain();

        // Reset mid-operation discards everything queued.
        drive(1, 12, 32'h300, 1, 13, 32'h301);
        drive(1, 14, 32'h302, 1, 15, 32'h303);
        rst_n = 1'b0;
        drive(1, 16, 32'h304, 0, 0, 0, 12, 13);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 14, 15);
        drive();
        check("post_rst_count", bus.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
